// File: rtl/sramlike_arbiter.sv
// sramlike_arbiter: shares one sram_like master port between the ibus and dbus,
// routing in-order data_ok responses back through a 1-bit owner FIFO.
module sramlike_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic        inst_cache,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic        data_cache,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic        m_cache,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t                     state_q, state_d;
    logic                       last_grant_q, last_grant_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       gi, gd, push, pop, full, head;

    // Owner and last_grant encode inst as 0 and data as 1.
    always_comb begin
        gi           = state_q == GRANT_I;
        gd           = state_q == GRANT_D;
        m_req        = gi ? inst_req   : gd & data_req;
        m_wr         = gi ? inst_wr    : gd & data_wr;
        m_cache      = gi ? inst_cache : gd & data_cache;
        m_size       = gi ? inst_size  : gd ? data_size  : 2'b0;
        m_addr       = gi ? inst_addr  : gd ? data_addr  : 32'b0;
        m_wdata      = gi ? inst_wdata : gd ? data_wdata : 32'b0;
        inst_addr_ok = gi & m_addr_ok;
        data_addr_ok = gd & m_addr_ok;
        push         = m_req & m_addr_ok;
        pop          = m_data_ok & (count_q != '0);
        full         = count_q == CW'(MAX_OUTSTANDING);
        head         = owner_q[rd_ptr_q];
        inst_data_ok = pop & ~head;
        data_data_ok = pop & head;
        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;
        owner_d      = owner_q;
        if (push)
            owner_d[wr_ptr_q] = gd;
        wr_ptr_d     = !push ? wr_ptr_q : wr_ptr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d     = !pop  ? rd_ptr_q : rd_ptr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr_q + 1'b1;
        count_d      = count_q + CW'(push) - CW'(pop);
        last_grant_d = push ? gd : last_grant_q;
        state_d      = state_q;
        // A pop this cycle frees a slot in time for the IDLE decision.
        if (state_q == IDLE) begin
            if (!full || pop)
                state_d = (inst_req && data_req) ? (last_grant_q ? GRANT_I : GRANT_D) :
                          inst_req ? GRANT_I : data_req ? GRANT_D : IDLE;
        end else if (push || (gi && !inst_req) || (gd && !data_req)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            owner_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_sramlike_arbiter.sv
// tb_sramlike_arbiter: directed checks of grant order, owner FIFO routing,
// full-FIFO stall, push/pop overlap, spurious responses and async reset.
module tb_sramlike_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0, inst_cache = 0;
    logic [1:0]  inst_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 0, data_wr = 0, data_cache = 0;
    logic [1:0]  data_size = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        m_req, m_wr, m_cache;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 0;
    logic        m_addr_ok = 0, m_data_ok = 0;
    int          errors = 0, checks = 0;

    sramlike_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clock(clock), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_cache(inst_cache), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_cache(data_cache), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_cache(m_cache), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        m_rdata = 32'hDEADBEEF;
        m_data_ok = 1;
        #2;
        chk("rst_m_req", m_req, 0);
        chk("rst_iaok", inst_addr_ok, 0);
        chk("rst_daok", data_addr_ok, 0);
        chk("rst_idok", inst_data_ok, 0);
        chk("rst_ddok", data_data_ok, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_irdata", inst_rdata, 32'hDEADBEEF);
        tick; tick;
        reset = 0;
        m_data_ok = 0;

        // single inst read
        inst_req = 1; inst_addr = 32'hBFC00000;
        #1 chk("t1_idle_m_req", m_req, 0);
        tick;
        m_addr_ok = 1;
        #1 chk("t1_m_req", m_req, 1);
        chk("t1_m_addr", m_addr, 32'hBFC00000);
        chk("t1_iaok", inst_addr_ok, 1);
        chk("t1_daok", data_addr_ok, 0);
        tick;
        inst_req = 0; m_addr_ok = 0;
        #1 chk("t1_iaok_off", inst_addr_ok, 0);
        tick; tick;
        m_data_ok = 1; m_rdata = 32'h3C1A0000;
        #1 chk("t1_idok", inst_data_ok, 1);
        chk("t1_ddok", data_data_ok, 0);
        chk("t1_irdata", inst_rdata, 32'h3C1A0000);
        tick;
        m_data_ok = 0;
        #1 chk("t1_idok_off", inst_data_ok, 0);

        // simultaneous requests from reset: data wins first
        reset = 1; #2 reset = 0;
        inst_req = 1; inst_addr = 32'h1000; inst_wr = 0;
        data_req = 1; data_addr = 32'h2000; data_wr = 1; data_wdata = 32'hAA55;
        m_addr_ok = 1;
        tick;
        #1 chk("t2_m_addr_d", m_addr, 32'h2000);
        chk("t2_daok", data_addr_ok, 1);
        chk("t2_iaok", inst_addr_ok, 0);
        chk("t2_m_wr", m_wr, 1);
        chk("t2_m_wdata", m_wdata, 32'hAA55);
        tick;
        data_req = 0;
        #1 chk("t2_gap_m_req", m_req, 0);
        tick;
        #1 chk("t2_m_addr_i", m_addr, 32'h1000);
        chk("t2_iaok2", inst_addr_ok, 1);
        chk("t2_m_wr_i", m_wr, 0);
        tick;
        inst_req = 0; m_addr_ok = 0;

        // FIFO full: third request must wait for a pop
        data_req = 1; data_addr = 32'h3000; data_wr = 0;
        #1 chk("t3_full0", m_req, 0);
        tick;
        #1 chk("t3_full1", m_req, 0);
        tick;
        #1 chk("t3_full2", m_req, 0);
        m_data_ok = 1; m_rdata = 32'h111;
        #1 chk("t3_ddok", data_data_ok, 1);
        chk("t3_idok", inst_data_ok, 0);
        chk("t3_drdata", data_rdata, 32'h111);
        tick;
        m_data_ok = 0;
        #1 chk("t3_grant", m_req, 1);
        chk("t3_m_addr", m_addr, 32'h3000);

        // push and pop in the same cycle
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h222;
        #1 chk("t4_idok", inst_data_ok, 1);
        chk("t4_ddok", data_data_ok, 0);
        chk("t4_daok", data_addr_ok, 1);
        tick;
        data_req = 0; m_addr_ok = 0; m_data_ok = 0;
        tick;
        m_data_ok = 1; m_rdata = 32'h333;
        #1 chk("t4_next_ddok", data_data_ok, 1);
        chk("t4_next_idok", inst_data_ok, 0);
        tick;

        // spurious response with empty FIFO
        #1 chk("t5_idok", inst_data_ok, 0);
        chk("t5_ddok", data_data_ok, 0);
        tick;
        m_data_ok = 0;
        inst_req = 1; inst_addr = 32'h4000; m_addr_ok = 1;
        tick;
        #1 chk("t5_iaok", inst_addr_ok, 1);
        tick;
        inst_req = 0; m_addr_ok = 0;
        m_data_ok = 1;
        #1 chk("t5_route_inst", inst_data_ok, 1);
        chk("t5_route_data", data_data_ok, 0);
        tick;
        #1 chk("t5_empty_idok", inst_data_ok, 0);
        chk("t5_empty_ddok", data_data_ok, 0);
        m_data_ok = 0;

        // async reset mid-flight
        inst_req = 1; inst_addr = 32'h5000; m_addr_ok = 1;
        tick;
        tick;
        inst_req = 0; m_addr_ok = 0;
        data_req = 1; data_addr = 32'h6000;
        tick;
        #1 chk("t6_pre_m_req", m_req, 1);
        #1 reset = 1;
        #1 chk("t6_rst_m_req", m_req, 0);
        chk("t6_rst_m_addr", m_addr, 0);
        data_req = 0;
        tick;
        reset = 0;
        m_data_ok = 1;
        #1 chk("t6_late_idok", inst_data_ok, 0);
        chk("t6_late_ddok", data_data_ok, 0);
        m_data_ok = 0;
        inst_req = 1; inst_addr = 32'h7000;
        data_req = 1; data_addr = 32'h8000;
        tick;
        #1 chk("t6_tie_data", m_addr, 32'h8000);
        inst_req = 0; data_req = 0;
        tick; tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
